rotor_stack: RTL and testbench

ROTOR_STACK -- requirements
Module: rotor_stack

---
 rtl/rotor_stack_pkg.sv | 24 ++
 rtl/rotor_stack_sub.sv | 33 +++
 rtl/rotor_stack.sv | 185 ++++++++++++++++++
 tb/tb_rotor_stack.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rotor_stack_pkg.sv
// Shared types for the rotor stack cipher.
//   state_e    : sequencer states, one character in flight at a time
//   cfg_kind_e : meaning of cfg_kind on a configuration write
package rotor_stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_FWD,
    ST_REFL,
    ST_BWD,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CFG_WIRE  = 2'd0,
    CFG_NOTCH = 2'd1,
    CFG_RING  = 2'd2
  } cfg_kind_e;

  // Rotor counter width; covers up to 8 rotors.
  localparam int RIDX_W = 3;

endpackage

// File: rtl/rotor_stack_sub.sv
// rotor_sub: one rotor contact pass, purely combinational.
//   s    = (pos - ring) mod ALPHA
//   c_o  = (map[(c_i + s) mod ALPHA] - s) mod ALPHA
// Ports: c_i (input char), pos_i/ring_i (rotor state), map_i (forward or
// backward wiring of the selected rotor), c_o (output char).
module rotor_sub
  import rotor_stack_pkg::*;
#(
  parameter int ALPHA = 26,
  parameter int W     = $clog2(ALPHA)
) (
  input  logic [W-1:0]            c_i,
  input  logic [W-1:0]            pos_i,
  input  logic [W-1:0]            ring_i,
  input  logic [ALPHA-1:0][W-1:0] map_i,
  output logic [W-1:0]            c_o
);

  // One extra bit so sums of two residues never overflow.
  localparam logic [W:0] AX = (W+1)'(ALPHA);

  logic [W:0] s, a, m;

  always_comb begin
    s = (pos_i >= ring_i) ? ({1'b0, pos_i} - {1'b0, ring_i})
                          : ({1'b0, pos_i} + AX - {1'b0, ring_i});
    a = {1'b0, c_i} + s;
    if (a >= AX) a = a - AX;
    m = {1'b0, map_i[a[W-1:0]]};
    c_o = (m >= s) ? W'(m - s) : W'(m + AX - s);
  end

endmodule

// File: rtl/rotor_stack.sv
// rotor_stack: Enigma-style stepping rotor cipher, one character at a time.
// A character walks STEP, forward through every rotor, the reflector, then
// back through every rotor, one rotor per cycle through a single shared
// rotor_sub; result pulses out_valid in DONE.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_we/sel/kind/idx/val, cfg_ready   wiring / notch / ring writes (IDLE)
//   set_in, init_pos_in   load start positions (rotor k at [k*W +: W])
//   in_valid/in_ready/char_in            character input handshake
//   out_valid, char_out   enciphered character (pulse / held)
//   pos_out               current rotor positions
module rotor_stack
  import rotor_stack_pkg::*;
#(
  parameter  int NUM_ROTORS = 3,
  parameter  int ALPHA      = 26,
  localparam int W          = $clog2(ALPHA)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_sel,
  input  logic [1:0]              cfg_kind,
  input  logic [W-1:0]            cfg_idx,
  input  logic [W-1:0]            cfg_val,
  output logic                    cfg_ready,
  input  logic                    set_in,
  input  logic [NUM_ROTORS*W-1:0] init_pos_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            char_in,
  output logic                    out_valid,
  output logic [W-1:0]            char_out,
  output logic [NUM_ROTORS*W-1:0] pos_out
);

  localparam logic [W:0] AX = (W+1)'(ALPHA);

  state_e                                  state_q;
  logic [RIDX_W-1:0]                       ridx_q;
  logic [W-1:0]                            char_q;
  logic                                    out_valid_q;
  logic [W-1:0]                            char_out_q;
  logic [NUM_ROTORS-1:0][W-1:0]            pos_q, ring_q, notch_q;
  logic [NUM_ROTORS-1:0][ALPHA-1:0][W-1:0] fwd_q, bwd_q;
  logic [ALPHA-1:0][W-1:0]                 refl_q;

  logic [NUM_ROTORS-1:0][W-1:0]            pos_step_d;
  logic [W-1:0]                            sub_pos, sub_ring, sub_out;
  logic [ALPHA-1:0][W-1:0]                 sub_map;
  logic                                    idx_ok, val_ok;

  function automatic logic [W-1:0] fold(input logic [W-1:0] v);
    return ({1'b0, v} >= AX) ? W'({1'b0, v} - AX) : v;
  endfunction

  assign in_ready  = (state_q == ST_IDLE) && !set_in;
  assign cfg_ready = (state_q == ST_IDLE) && !set_in;
  assign out_valid = out_valid_q;
  assign char_out  = char_out_q;
  assign pos_out   = pos_q;
  assign idx_ok    = {1'b0, cfg_idx} < AX;
  assign val_ok    = {1'b0, cfg_val} < AX;

  // Step decisions all look at pre-step positions. Rotors strictly between
  // the first and last also step on their own notch (double step).
  for (genvar k = 0; k < NUM_ROTORS; k++) begin : g_step
    logic adv;
    if (k == 0) begin : g_fast
      assign adv = 1'b1;
    end else if (k <= NUM_ROTORS - 2) begin : g_mid
      assign adv = (pos_q[k-1] == notch_q[k-1]) || (pos_q[k] == notch_q[k]);
    end else begin : g_last
      assign adv = (pos_q[k-1] == notch_q[k-1]);
    end
    assign pos_step_d[k] = !adv ? pos_q[k] :
                           (pos_q[k] == W'(ALPHA - 1)) ? '0 : pos_q[k] + 1'b1;
  end

  // Feed the shared rotor pass with the rotor selected by ridx_q.
  always_comb begin
    sub_pos  = '0;
    sub_ring = '0;
    sub_map  = '0;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      if (ridx_q == RIDX_W'(k)) begin
        sub_pos  = pos_q[k];
        sub_ring = ring_q[k];
        sub_map  = (state_q == ST_BWD) ? bwd_q[k] : fwd_q[k];
      end
    end
  end

  rotor_sub #(.ALPHA(ALPHA), .W(W)) u_sub (
    .c_i   (char_q),
    .pos_i (sub_pos),
    .ring_i(sub_ring),
    .map_i (sub_map),
    .c_o   (sub_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ridx_q      <= '0;
      char_q      <= '0;
      out_valid_q <= 1'b0;
      char_out_q  <= '0;
      for (int k = 0; k < NUM_ROTORS; k++) begin
        pos_q[k]   <= '0;
        ring_q[k]  <= '0;
        notch_q[k] <= W'(ALPHA - 1);
        for (int i = 0; i < ALPHA; i++) begin
          fwd_q[k][i] <= W'(i);
          bwd_q[k][i] <= W'(i);
        end
      end
      for (int i = 0; i < ALPHA; i++) refl_q[i] <= W'(i ^ 1);
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (set_in) begin
            for (int k = 0; k < NUM_ROTORS; k++)
              pos_q[k] <= fold(init_pos_in[k*W +: W]);
          end else begin
            if (in_valid) begin
              char_q  <= fold(char_in);
              state_q <= ST_STEP;
            end
            if (cfg_we) begin
              for (int k = 0; k < NUM_ROTORS; k++) begin
                if (cfg_sel == 4'(k)) begin
                  case (cfg_kind)
                    CFG_WIRE: if (idx_ok && val_ok) begin
                      fwd_q[k][cfg_idx] <= cfg_val;
                      bwd_q[k][cfg_val] <= cfg_idx;
                    end
                    CFG_NOTCH: if (val_ok) notch_q[k] <= cfg_val;
                    CFG_RING:  if (val_ok) ring_q[k]  <= cfg_val;
                    default: ;
                  endcase
                end
              end
              // Reflector writes keep the table an involution.
              if (cfg_sel == 4'(NUM_ROTORS) && cfg_kind == CFG_WIRE &&
                  idx_ok && val_ok) begin
                refl_q[cfg_idx] <= cfg_val;
                refl_q[cfg_val] <= cfg_idx;
              end
            end
          end
        end
        ST_STEP: begin
          pos_q   <= pos_step_d;
          ridx_q  <= '0;
          state_q <= ST_FWD;
        end
        ST_FWD: begin
          char_q <= sub_out;
          if (ridx_q == RIDX_W'(NUM_ROTORS - 1)) state_q <= ST_REFL;
          else                                   ridx_q  <= ridx_q + 1'b1;
        end
        ST_REFL: begin
          char_q  <= refl_q[char_q];
          ridx_q  <= RIDX_W'(NUM_ROTORS - 1);
          state_q <= ST_BWD;
        end
        ST_BWD: begin
          char_q <= sub_out;
          if (ridx_q == '0) begin
            char_out_q  <= sub_out;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            ridx_q <= ridx_q - 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotor_stack.sv
module tb_rotor_stack;

  localparam int N = 3;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_we;
  logic [3:0]     cfg_sel;
  logic [1:0]     cfg_kind;
  logic [W-1:0]   cfg_idx, cfg_val;
  logic           cfg_ready;
  logic           set_in;
  logic [N*W-1:0] init_pos_in;
  logic           in_valid, in_ready;
  logic [W-1:0]   char_in;
  logic           out_valid;
  logic [W-1:0]   char_out;
  logic [N*W-1:0] pos_out;

  int checks   = 0;
  int failures = 0;

  rotor_stack #(.NUM_ROTORS(N), .ALPHA(26)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_kind(cfg_kind),
    .cfg_idx(cfg_idx), .cfg_val(cfg_val), .cfg_ready(cfg_ready),
    .set_in(set_in), .init_pos_in(init_pos_in),
    .in_valid(in_valid), .in_ready(in_ready), .char_in(char_in),
    .out_valid(out_valid), .char_out(char_out), .pos_out(pos_out)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int sel, input int kind, input int idx, input int val);
    cfg_we = 1'b1; cfg_sel = 4'(sel); cfg_kind = 2'(kind);
    cfg_idx = W'(idx); cfg_val = W'(val);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_pos(input int p0, input int p1, input int p2);
    set_in = 1'b1;
    init_pos_in = {W'(p2), W'(p1), W'(p0)};
    @(negedge clk);
    set_in = 1'b0;
  endtask

  // Returns the result and the number of edges from accept to out_valid.
  task automatic encrypt(input int c, output logic [W-1:0] res, output int lat);
    in_valid = 1'b1; char_in = W'(c);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = char_out;
    @(negedge clk);
  endtask

  task automatic load_wiring(input int sel, input string s);
    for (int i = 0; i < 26; i++) cfg_write(sel, 0, i, int'(s[i]) - 65);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (char_out !== 5'd0) begin failures++; $display("FAIL reset_char_out got=%0d exp=0", char_out); end
    checks++; if (pos_out !== 15'd0) begin failures++; $display("FAIL reset_pos got=%h exp=0", pos_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b exp=1", cfg_ready); end
  endtask

  task automatic test_identity();
    logic [W-1:0] r; int lat;
    do_reset();
    encrypt(0, r, lat);
    checks++; if (lat !== 9) begin failures++; $display("FAIL identity_latency got=%0d exp=9", lat); end
    checks++; if (r !== 5'd1) begin failures++; $display("FAIL identity_out got=%0d exp=1", r); end
    checks++; if (pos_out !== {5'd0, 5'd0, 5'd1}) begin failures++; $display("FAIL identity_pos got=%h exp=%h", pos_out, {5'd0, 5'd0, 5'd1}); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL identity_pulse got=%0b exp=0", out_valid); end
    checks++; if (char_out !== 5'd1) begin failures++; $display("FAIL identity_hold got=%0d exp=1", char_out); end
    encrypt(6, r, lat);
    checks++; if (r !== 5'd7) begin failures++; $display("FAIL identity_out2 got=%0d exp=7", r); end
  endtask

  task automatic test_double_step();
    logic [W-1:0] r; int lat;
    do_reset();
    cfg_write(0, 1, 0, 16);
    cfg_write(1, 1, 0, 4);
    set_pos(16, 3, 0);
    encrypt(0, r, lat);
    checks++; if (pos_out !== {5'd0, 5'd4, 5'd17}) begin failures++; $display("FAIL double_step_1 got=%h exp=%h", pos_out, {5'd0, 5'd4, 5'd17}); end
    encrypt(0, r, lat);
    checks++; if (pos_out !== {5'd1, 5'd5, 5'd18}) begin failures++; $display("FAIL double_step_2 got=%h exp=%h", pos_out, {5'd1, 5'd5, 5'd18}); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] r; int lat;
    do_reset();
    cfg_write(0, 1, 0, 25);
    set_pos(25, 0, 0);
    encrypt(3, r, lat);
    checks++; if (pos_out !== {5'd0, 5'd1, 5'd0}) begin failures++; $display("FAIL wrap_pos got=%h exp=%h", pos_out, {5'd0, 5'd1, 5'd0}); end
  endtask

  task automatic test_enigma();
    string pt = "AAAAA";
    string ct = "BDZGO";
    logic [W-1:0] r; int lat;
    do_reset();
    load_wiring(0, "BDFHJLCPRTXVZNYEIWGAKMOUSQ");   // III, fast rotor
    load_wiring(1, "AJDKSIRUXBLHWTMCQGZNPYFVOE");   // II
    load_wiring(2, "EKMFLGDQVZNTOWYHXUSPAIBRCJ");   // I
    load_wiring(3, "YRUHQSLDPXNGOKMIEBFZCWVJAT");   // reflector B
    cfg_write(0, 1, 0, 21);
    cfg_write(1, 1, 0, 4);
    cfg_write(2, 1, 0, 16);
    set_pos(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      encrypt(int'(pt[i]) - 65, r, lat);
      checks++; if (r !== 5'(int'(ct[i]) - 65)) begin failures++; $display("FAIL enigma_enc[%0d] got=%0d exp=%0d", i, r, int'(ct[i]) - 65); end
    end
    set_pos(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      encrypt(int'(ct[i]) - 65, r, lat);
      checks++; if (r !== 5'(int'(pt[i]) - 65)) begin failures++; $display("FAIL enigma_dec[%0d] got=%0d exp=%0d", i, r, int'(pt[i]) - 65); end
    end
    // Ring B at position B gives the same offsets as ring A at A.
    for (int k = 0; k < 3; k++) cfg_write(k, 2, 0, 1);
    set_pos(1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      encrypt(int'(pt[i]) - 65, r, lat);
      checks++; if (r !== 5'(int'(ct[i]) - 65)) begin failures++; $display("FAIL enigma_ring[%0d] got=%0d exp=%0d", i, r, int'(ct[i]) - 65); end
    end
  endtask

  task automatic test_busy_cfg();
    logic [W-1:0] r; int lat;
    do_reset();
    in_valid = 1'b1; char_in = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL busy_cfg_ready got=%0b exp=0", cfg_ready); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%0b exp=0", in_ready); end
    cfg_we = 1'b1; cfg_sel = 4'd3; cfg_kind = 2'd0; cfg_idx = 5'd0; cfg_val = 5'd4;
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    cfg_we = 1'b0;
    checks++; if (char_out !== 5'd1 || lat !== 9) begin failures++; $display("FAIL busy_inflight got=%0d/%0d exp=1/9", char_out, lat); end
    @(negedge clk);
    encrypt(0, r, lat);
    checks++; if (r !== 5'd1) begin failures++; $display("FAIL busy_table_unchanged got=%0d exp=1", r); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    in_valid = 1'b1; char_in = 5'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);            // now in FWD
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_idle got=%0b exp=1", in_ready); end
    checks++; if (pos_out !== 15'd0) begin failures++; $display("FAIL reset_mid_pos got=%h exp=0", pos_out); end
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid_no_out got=%0d exp=0", seen); end
  endtask

  task automatic test_limits();
    logic [W-1:0] r; int lat;
    do_reset();
    cfg_write(5, 0, 0, 4);     // no such table
    cfg_write(3, 0, 0, 30);    // value out of alphabet
    cfg_write(3, 0, 28, 2);    // index out of alphabet
    encrypt(0, r, lat);
    checks++; if (r !== 5'd1) begin failures++; $display("FAIL limits_ignored_writes got=%0d exp=1", r); end
    encrypt(2, r, lat);
    checks++; if (r !== 5'd3) begin failures++; $display("FAIL limits_ignored_idx got=%0d exp=3", r); end
    encrypt(27, r, lat);
    checks++; if (r !== 5'd0) begin failures++; $display("FAIL limits_char_fold got=%0d exp=0", r); end
    set_pos(3, 27, 26);
    checks++; if (pos_out !== {5'd0, 5'd1, 5'd3}) begin failures++; $display("FAIL limits_pos_fold got=%h exp=%h", pos_out, {5'd0, 5'd1, 5'd3}); end
    // set_in wins over in_valid in the same cycle
    set_in = 1'b1; in_valid = 1'b1; char_in = 5'd0;
    init_pos_in = {5'd0, 5'd0, 5'd5};
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL priority_in_ready got=%0b exp=0", in_ready); end
    @(negedge clk);
    set_in = 1'b0; in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (pos_out !== {5'd0, 5'd0, 5'd5}) begin failures++; $display("FAIL priority_pos got=%h exp=%h", pos_out, {5'd0, 5'd0, 5'd5}); end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_kind = '0; cfg_idx = '0; cfg_val = '0;
    set_in = 1'b0; init_pos_in = '0; in_valid = 1'b0; char_in = '0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_double_step();
    test_wrap();
    test_enigma();
    test_busy_cfg();
    test_reset_mid();
    test_limits();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
